// File: rtl/sb_drain_arbiter.sv
// sb_drain_arbiter
// Shares the single data-cache port between pipeline loads and the store
// buffer drain path. It keeps at most one cache write outstanding, pops the
// store buffer head when that write completes, and forces a drain when the
// buffer is full or a waiting drain has lost to loads too many times. A
// flush request empties the buffer and then pulses flush_done.
//
// Optional build macro: SB_ARB_PERF_EN adds two free-running 32-bit
// performance counters (perf_drains, perf_ld_stalls).
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   ld_req             memory stage wants the cache port for a load
//   sb_empty, sb_full  store buffer occupancy flags
//   sb_head_addr/data  oldest store buffer entry
//   flush_req          level request to drain the buffer completely
//   cache_ack          cache finished the presented write
//   ld_grant           load owns the port this cycle (combinational)
//   stall_pipe         load requested but not granted (combinational)
//   cache_wr_en/addr/data  registered cache write request
//   sb_pop             one-cycle registered dequeue pulse
//   flush_done         one-cycle registered flush completion pulse
//   perf_drains, perf_ld_stalls  (SB_ARB_PERF_EN only) event counters

module sb_drain_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic              sb_empty,
    input  logic              sb_full,
    input  logic [ADDR_W-1:0] sb_head_addr,
    input  logic [DATA_W-1:0] sb_head_data,
    input  logic              flush_req,
    input  logic              cache_ack,
    output logic              ld_grant,
    output logic              stall_pipe,
    output logic              cache_wr_en,
    output logic [ADDR_W-1:0] cache_wr_addr,
    output logic [DATA_W-1:0] cache_wr_data,
    output logic              sb_pop,
`ifdef SB_ARB_PERF_EN
    output logic [31:0]       perf_drains,
    output logic [31:0]       perf_ld_stalls,
`endif
    output logic              flush_done
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FL_DRAIN,
        FL_SETTLE,
        FL_DONE
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     starve_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              pop_q;
    logic              done_q;
    logic              force_drain;

    // A pending drain wins over loads once the buffer is full or the drain
    // has been passed over STARVE_MAX times in a row.
    assign force_drain = sb_full || (starve_q == STARVE_LIMIT);

    assign ld_grant   = !reset && (state_q == IDLE) && ld_req && !flush_req &&
                        !(force_drain && !sb_empty);
    assign stall_pipe = ld_req && !ld_grant;

    assign cache_wr_en   = wr_en_q;
    assign cache_wr_addr = wr_addr_q;
    assign cache_wr_data = wr_data_q;
    assign sb_pop        = pop_q;
    assign flush_done    = done_q;

    // Arbitration / drain sequencer. The pulse outputs default low every
    // cycle. In FL_DRAIN, wr_en_q tells apart "waiting to issue" from
    // "waiting for the ack", so a flush reuses one state per entry. An ack
    // is only looked at while a write is already outstanding, so an ack in
    // the issue cycle is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pop_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pop_q  <= 1'b0;
            done_q <= 1'b0;
            if (sb_empty) begin
                starve_q <= '0;
            end
            case (state_q)
                IDLE: begin
                    if (flush_req) begin
                        state_q <= FL_DRAIN;
                    end else if (!sb_empty && (!ld_req || force_drain) && !pop_q) begin
                        // pop_q blocks a back-to-back issue so the buffer's
                        // head and empty flag can catch up with the pop.
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= sb_head_addr;
                        wr_data_q <= sb_head_data;
                        starve_q  <= '0;
                        state_q   <= DRAIN;
                    end else if (!sb_empty && ld_grant && (starve_q != STARVE_LIMIT)) begin
                        starve_q <= starve_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (cache_ack) begin
                        wr_en_q <= 1'b0;
                        pop_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                FL_DRAIN: begin
                    if (wr_en_q) begin
                        if (cache_ack) begin
                            wr_en_q <= 1'b0;
                            pop_q   <= 1'b1;
                            state_q <= FL_SETTLE;
                        end
                    end else if (sb_empty) begin
                        done_q  <= 1'b1;
                        state_q <= FL_DONE;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= sb_head_addr;
                        wr_data_q <= sb_head_data;
                        starve_q  <= '0;
                    end
                end
                FL_SETTLE: begin
                    state_q <= FL_DRAIN;
                end
                FL_DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SB_ARB_PERF_EN
    logic [31:0] perf_drains_q;
    logic [31:0] perf_ld_stalls_q;

    // Wrapping event counters: completed drains and stalled load cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_drains_q    <= '0;
            perf_ld_stalls_q <= '0;
        end else begin
            if (pop_q) begin
                perf_drains_q <= perf_drains_q + 32'd1;
            end
            if (stall_pipe) begin
                perf_ld_stalls_q <= perf_ld_stalls_q + 32'd1;
            end
        end
    end

    assign perf_drains    = perf_drains_q;
    assign perf_ld_stalls = perf_ld_stalls_q;
`endif

endmodule

// File: tb/tb_sb_drain_arbiter.sv
// tb_sb_drain_arbiter
// Directed bench for sb_drain_arbiter. A tiny queue stands in for the store
// buffer: it dequeues its head one edge after sb_pop is seen, the way a real
// buffer registers the pop. Outputs are sampled a couple of time units after
// the rising edge.

module tb_sb_drain_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req;
    logic        sb_empty;
    logic        sb_full;
    logic [31:0] sb_head_addr;
    logic [31:0] sb_head_data;
    logic        flush_req;
    logic        cache_ack;
    logic        ld_grant;
    logic        stall_pipe;
    logic        cache_wr_en;
    logic [31:0] cache_wr_addr;
    logic [31:0] cache_wr_data;
    logic        sb_pop;
    logic        flush_done;
`ifdef SB_ARB_PERF_EN
    logic [31:0] perfDrains;
    logic [31:0] perfLdStalls;
`endif

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [31:0] qAddr[$];
    logic [31:0] qData[$];
    logic        fullOverride = 1'b0;
    logic        popSeen = 1'b0;

    sb_drain_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ld_req(ld_req),
        .sb_empty(sb_empty),
        .sb_full(sb_full),
        .sb_head_addr(sb_head_addr),
        .sb_head_data(sb_head_data),
        .flush_req(flush_req),
        .cache_ack(cache_ack),
        .ld_grant(ld_grant),
        .stall_pipe(stall_pipe),
        .cache_wr_en(cache_wr_en),
        .cache_wr_addr(cache_wr_addr),
        .cache_wr_data(cache_wr_data),
        .sb_pop(sb_pop),
`ifdef SB_ARB_PERF_EN
        .perf_drains(perfDrains),
        .perf_ld_stalls(perfLdStalls),
`endif
        .flush_done(flush_done)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the buffer-side inputs from the model queue.
    task automatic syncSb();
        sb_empty     = (qAddr.size() == 0);
        sb_full      = fullOverride;
        sb_head_addr = (qAddr.size() == 0) ? 32'd0 : qAddr[0];
        sb_head_data = (qData.size() == 0) ? 32'd0 : qData[0];
    endtask

    task automatic pushEntry(input logic [31:0] a, input logic [31:0] d);
        qAddr.push_back(a);
        qData.push_back(d);
        syncSb();
    endtask

    // Advance one clock, let the buffer model react to last cycle's pop,
    // and leave the combinational outputs settled for checking.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (popSeen && qAddr.size() > 0) begin
            void'(qAddr.pop_front());
            void'(qData.pop_front());
            fullOverride = 1'b0;
        end
        syncSb();
        popSeen = sb_pop;
        if (sb_pop) begin
            checkOutput("popNotEmpty", 32'(sb_empty), 32'd0);
        end
        #1;
    endtask

    initial begin : mainSeq
        int          cyc;
        int          doneCnt;
        int          doneIdx;
        int          grantCnt;
        int          wrAge;
        int          popIdx[$];
        logic [31:0] issued[$];

        reset     = 1'b1;
        ld_req    = 1'b1;
        flush_req = 1'b0;
        cache_ack = 1'b0;
        syncSb();

        // Reset state, including ld_grant held low while reset is high.
        applyStimulus();
        applyStimulus();
        checkOutput("rstWrEn", 32'(cache_wr_en), 32'd0);
        checkOutput("rstPop", 32'(sb_pop), 32'd0);
        checkOutput("rstDone", 32'(flush_done), 32'd0);
        checkOutput("rstAddr", cache_wr_addr, 32'd0);
        checkOutput("rstData", cache_wr_data, 32'd0);
        checkOutput("rstGrant", 32'(ld_grant), 32'd0);

        reset  = 1'b0;
        ld_req = 1'b0;
        applyStimulus();

        // Single store into an idle port, ack one cycle after the request.
        pushEntry(32'h0000_00AA, 32'h0000_DDDD);
        applyStimulus();
        checkOutput("st1WrEn", 32'(cache_wr_en), 32'd1);
        checkOutput("st1Addr", cache_wr_addr, 32'h0000_00AA);
        checkOutput("st1Data", cache_wr_data, 32'h0000_DDDD);
        checkOutput("st1NoPopYet", 32'(sb_pop), 32'd0);
        cache_ack = 1'b1;
        applyStimulus();
        checkOutput("st1WrEnDrop", 32'(cache_wr_en), 32'd0);
        checkOutput("st1Pop", 32'(sb_pop), 32'd1);
        cache_ack = 1'b0;
        applyStimulus();
        checkOutput("st1PopOnce", 32'(sb_pop), 32'd0);
        checkOutput("st1NoReissue", 32'(cache_wr_en), 32'd0);
        ld_req = 1'b1;
        #1;
        checkOutput("st1BackIdle", 32'(ld_grant), 32'd1);

        // Loads win four times, then the starved drain is forced.
        pushEntry(32'h0000_0010, 32'h0000_1111);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("starveGrant%0d", i), 32'(ld_grant), 32'd1);
            applyStimulus();
        end
        checkOutput("starveForceGrant", 32'(ld_grant), 32'd0);
        checkOutput("starveForceStall", 32'(stall_pipe), 32'd1);
        applyStimulus();
        checkOutput("starveWrEn", 32'(cache_wr_en), 32'd1);
        checkOutput("starveAddr", cache_wr_addr, 32'h0000_0010);
        checkOutput("starveDrainStall", 32'(stall_pipe), 32'd1);
        cache_ack = 1'b1;
        applyStimulus();
        cache_ack = 1'b0;
        checkOutput("starvePop", 32'(sb_pop), 32'd1);
        checkOutput("starveGrantBack", 32'(ld_grant), 32'd1);
        applyStimulus();
        applyStimulus();

        // Full buffer drains immediately even with a load pending.
        fullOverride = 1'b1;
        pushEntry(32'h0000_0020, 32'h0000_2222);
        #1;
        checkOutput("fullGrant", 32'(ld_grant), 32'd0);
        checkOutput("fullStall", 32'(stall_pipe), 32'd1);
        applyStimulus();
        checkOutput("fullWrEn", 32'(cache_wr_en), 32'd1);
        checkOutput("fullAddr", cache_wr_addr, 32'h0000_0020);
        checkOutput("fullDrainStall", 32'(stall_pipe), 32'd1);
        cache_ack = 1'b1;
        applyStimulus();
        cache_ack = 1'b0;
        checkOutput("fullPop", 32'(sb_pop), 32'd1);
        applyStimulus();
        checkOutput("fullGrantBack", 32'(ld_grant), 32'd1);

        // Flush of three entries, ack two cycles after each issue, flush_req
        // dropped early, load requested throughout.
        cyc      = 0;
        doneCnt  = 0;
        doneIdx  = -1;
        grantCnt = 0;
        wrAge    = 0;
        flush_req = 1'b1;
        pushEntry(32'h0000_0030, 32'h0000_3030);
        pushEntry(32'h0000_0031, 32'h0000_3131);
        pushEntry(32'h0000_0032, 32'h0000_3232);
        #1;
        if (ld_grant) grantCnt++;
        while (doneCnt == 0 && cyc < 60) begin
            applyStimulus();
            cyc++;
            if (cyc == 1) flush_req = 1'b0;
            if (cache_wr_en) wrAge++;
            else wrAge = 0;
            if (wrAge == 1) issued.push_back(cache_wr_addr);
            cache_ack = (wrAge == 2);
            if (sb_pop) popIdx.push_back(cyc);
            if (flush_done) begin
                doneCnt++;
                doneIdx = cyc;
            end
            if (ld_grant) grantCnt++;
        end
        cache_ack = 1'b0;
        checkOutput("flushDoneSeen", 32'(doneCnt), 32'd1);
        checkOutput("flushPopCount", 32'(popIdx.size()), 32'd3);
        checkOutput("flushIssueCount", 32'(issued.size()), 32'd3);
        checkOutput("flushNoGrant", 32'(grantCnt), 32'd0);
        if (issued.size() == 3) begin
            checkOutput("flushAddr0", issued[0], 32'h0000_0030);
            checkOutput("flushAddr1", issued[1], 32'h0000_0031);
            checkOutput("flushAddr2", issued[2], 32'h0000_0032);
        end
        if (popIdx.size() == 3) begin
            checkOutput("flushPopGap01", 32'(popIdx[1] - popIdx[0]), 32'd4);
            checkOutput("flushPopGap12", 32'(popIdx[2] - popIdx[1]), 32'd4);
            checkOutput("flushDoneAfterPop", 32'(doneIdx - popIdx[2]), 32'd2);
        end
        applyStimulus();
        checkOutput("flushDonePulse", 32'(flush_done), 32'd0);
        checkOutput("flushGrantBack", 32'(ld_grant), 32'd1);

        // Flush with an empty buffer: flush_done two cycles on, no write.
        ld_req    = 1'b0;
        flush_req = 1'b1;
        applyStimulus();
        flush_req = 1'b0;
        checkOutput("eflDone0", 32'(flush_done), 32'd0);
        checkOutput("eflWrEn0", 32'(cache_wr_en), 32'd0);
        applyStimulus();
        checkOutput("eflDone1", 32'(flush_done), 32'd1);
        checkOutput("eflWrEn1", 32'(cache_wr_en), 32'd0);
        applyStimulus();
        checkOutput("eflDone2", 32'(flush_done), 32'd0);

        // Reset in the middle of an un-acked drain, then a clean retry.
        pushEntry(32'h0000_00BB, 32'h0000_FFFF);
        applyStimulus();
        checkOutput("rmdWrEn", 32'(cache_wr_en), 32'd1);
        checkOutput("rmdAddr", cache_wr_addr, 32'h0000_00BB);
        reset  = 1'b1;
        ld_req = 1'b1;
        applyStimulus();
        checkOutput("rmdWrEnDrop", 32'(cache_wr_en), 32'd0);
        checkOutput("rmdNoPop", 32'(sb_pop), 32'd0);
        checkOutput("rmdAddrClr", cache_wr_addr, 32'd0);
        checkOutput("rmdGrant", 32'(ld_grant), 32'd0);
        reset  = 1'b0;
        ld_req = 1'b0;
        applyStimulus();
        checkOutput("rmdRetryWrEn", 32'(cache_wr_en), 32'd1);
        checkOutput("rmdRetryAddr", cache_wr_addr, 32'h0000_00BB);
        checkOutput("rmdRetryData", cache_wr_data, 32'h0000_FFFF);
        cache_ack = 1'b1;
        applyStimulus();
        cache_ack = 1'b0;
        checkOutput("rmdRetryPop", 32'(sb_pop), 32'd1);
        applyStimulus();
        checkOutput("rmdRetryPopEnd", 32'(sb_pop), 32'd0);
        checkOutput("rmdRetryIdle", 32'(cache_wr_en), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/sb_drain_arbiter.md
Name: sb_drain_arbiter

Overview:
- Arbitrates the single data-cache access port between pipeline loads and the store buffer drain path.
- Sequences head-of-buffer writes into the cache: one outstanding write at a time, a pop on completion, forced drain when the buffer is full or a drain has been starved.
- Implements a flush (fence) sequence that empties the store buffer before acknowledging.
- Sits between the store buffer, the memory stage and the data cache.

Parameters:
- ADDR_W, 32, store address width (matches SB_ADDR_WIDTH).
- DATA_W, 32, store data width (matches SB_DATA_WIDTH).
- STARVE_MAX, 4, number of consecutive cycles a pending drain may lose to loads before it is forced.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  memory stage requests the cache port for a load this cycle.
- sb_empty  in  1  store buffer holds no valid entry.
- sb_full  in  1  store buffer has no free entry.
- sb_head_addr  in  ADDR_W  address of the oldest store buffer entry.
- sb_head_data  in  DATA_W  data of the oldest store buffer entry.
- flush_req  in  1  level request to drain the buffer completely.
- cache_ack  in  1  cache has completed the presented write.
- ld_grant  out  1  load owns the port this cycle (combinational).
- stall_pipe  out  1  ld_req && !ld_grant (combinational).
- cache_wr_en  out  1  write request to the cache (registered).
- cache_wr_addr  out  ADDR_W  registered write address.
- cache_wr_data  out  DATA_W  registered write data.
- sb_pop  out  1  one-cycle pulse that dequeues the store buffer head (registered).
- flush_done  out  1  one-cycle pulse when a flush has completed (registered).

Behaviour:
- States: IDLE, DRAIN, FL_DRAIN, FL_SETTLE, FL_DONE.
- Reset: state IDLE, starve_cnt 0. cache_wr_en, sb_pop and flush_done are 0. cache_wr_addr and cache_wr_data are 0. ld_grant = 0 during reset.
- Reset mid-write drops cache_wr_en at the next edge; no pop is issued for the abandoned write.
- force = sb_full || (starve_cnt == STARVE_MAX).
- ld_grant = (state == IDLE) && ld_req && !flush_req && !(force && !sb_empty). In every other state ld_grant = 0.
- IDLE transitions, in priority order:
  - flush_req -> FL_DRAIN.
  - !sb_empty && (!ld_req || force) -> DRAIN. On the same edge, latch sb_head_addr/sb_head_data into cache_wr_addr/cache_wr_data and set cache_wr_en = 1.
- DRAIN:
  - cache_wr_en and the address/data registers are held stable until cache_ack.
  - On cache_ack: cache_wr_en -> 0, sb_pop = 1 for one cycle, go to IDLE.
  - A drain is never re-issued in the cycle following a pop, because sb_pop blocks the IDLE -> DRAIN transition for one cycle. This lets sb_empty and the head update settle.
  - cache_ack in the same cycle the write is issued does not count; ack is only sampled in DRAIN and FL_DRAIN.
- starve_cnt:
  - In IDLE, increments (saturating at STARVE_MAX) when !sb_empty and ld_grant = 1.
  - Cleared on every DRAIN or FL_DRAIN issue.
  - Cleared when sb_empty = 1.
- FL_DRAIN:
  - If sb_empty -> FL_DONE.
  - Otherwise issue a write exactly as in DRAIN. On cache_ack: sb_pop pulse, go to FL_SETTLE.
- FL_SETTLE: one cycle, then -> FL_DRAIN.
- FL_DONE: flush_done = 1 for one cycle, then -> IDLE. A second flush starts only if flush_req is still high in IDLE.
- flush_req deasserted mid-flush is ignored; the flush runs to completion.
- A flush with an empty buffer completes with flush_done 2 cycles after flush_req is sampled.
- sb_pop is never asserted when sb_empty = 1.
- Only one write is outstanding at any time.

Optional Feature:
- Macro: SB_ARB_PERF_EN.
- Defined: adds output ports perf_drains (32 bits) and perf_ld_stalls (32 bits).
  - perf_drains increments on each sb_pop.
  - perf_ld_stalls increments on each cycle with stall_pipe = 1.
  - Both wrap modulo 2^32 and are cleared by reset.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Store into an empty port: sb_empty = 0, head = 0x000000AA/0x0000DDDD, ld_req = 0, cache_ack one cycle after cache_wr_en.
  -> cache_wr_en high with addr 0xAA, data 0xDDDD; sb_pop pulses exactly once; state returns to IDLE.
- Load priority: ld_req = 1 and buffer non-empty with 1 entry.
  -> ld_grant = 1 for 4 cycles, then cycle 5 forces DRAIN with ld_grant = 0 and stall_pipe = 1. After the ack, ld_grant returns to 1.
- Full buffer: sb_full = 1 and ld_req = 1 in IDLE.
  -> immediate DRAIN, ld_grant = 0, stall_pipe = 1 until the pop.
- Flush: flush_req = 1 with 3 entries and cache_ack 2 cycles after each issue.
  -> 3 sb_pop pulses, each separated by a FL_SETTLE cycle. flush_done pulses once after sb_empty; no load granted during the flush.
- Empty flush: flush_req = 1 with sb_empty = 1.
  -> flush_done is asserted 2 cycles later, and no cache_wr_en is asserted.
- Reset mid-DRAIN: reset = 1 while cache_wr_en = 1 (addr 0xBB), with no ack.
  -> next edge: cache_wr_en = 0, sb_pop = 0, state IDLE, starve_cnt = 0. After reset the entry drains normally with addr 0xBB, data 0xFFFF.
